// File: rtl/clock_period_meter.sv
// Clock/pulse period meter: measures the period and high time of sig_in in clk cycles,
// with a one-cycle valid strobe, a measured level, a sticky timeout and a wrapping measurement count.
module clock_period_meter #(
  parameter int             N       = 30,
  parameter logic [N-1:0]   TIMEOUT = N'(500000000)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sig_in,
  input  logic         enable,
  output logic [N-1:0] period,
  output logic [N-1:0] high_time,
  output logic         valid,
  output logic         measured,
  output logic         timeout,
  output logic [7:0]   meas_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] cnt, cnt_d;
  logic [N-1:0] high_cap;
  logic         s1, s2, s3;
  logic         rise, fall;
  logic         do_meas, do_to, do_cap;

  // Input synchroniser plus delay flop for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt;
    do_meas = 1'b0;
    do_to   = 1'b0;
    do_cap  = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ARMED;
          cnt_d   = '0;
        end
        ARMED: begin
          if (rise) begin
            state_d = MEASURE;
            cnt_d   = N'(1);
          end
        end
        MEASURE: begin
          do_cap = fall;
          // A rise wins over the timeout check in the same cycle
          if (rise) begin
            do_meas = 1'b1;
            cnt_d   = N'(1);
          end else if (cnt == TIMEOUT) begin
            do_to   = 1'b1;
            state_d = ARMED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + N'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Counter, capture registers and result outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt        <= '0;
      high_cap   <= '0;
      period     <= '0;
      high_time  <= '0;
      valid      <= 1'b0;
      measured   <= 1'b0;
      timeout    <= 1'b0;
      meas_count <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt     <= cnt_d;
      valid   <= do_meas;
      if (do_cap) high_cap <= cnt;
      if (do_meas) begin
        period     <= cnt;
        high_time  <= high_cap;
        measured   <= 1'b1;
        timeout    <= 1'b0;
        meas_count <= meas_count + 8'd1;
      end
      if (do_to) begin
        timeout  <= 1'b1;
        measured <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter (TIMEOUT overridden to 50): periodic input,
// full-speed toggle, timeout, enable drop, async reset and meas_count wrap.
module tb_clock_period_meter;

  localparam int N = 30;

  logic         clk;
  logic         reset;
  logic         sig_in;
  logic         enable;
  logic [N-1:0] period;
  logic [N-1:0] high_time;
  logic         valid;
  logic         measured;
  logic         timeout;
  logic [7:0]   meas_count;

  int           n_checks = 0;
  int           n_fail   = 0;
  int           nval     = 0;
  int           wrap_seen = 0;
  logic [7:0]   mc_exp   = 8'd0;
  logic [7:0]   prev_mc  = 8'd0;
  bit           chk_en   = 1'b0;
  int           exp_per  = 0;
  int           exp_hi   = 0;

  clock_period_meter #(.N(N), .TIMEOUT(30'd50)) dut (
    .clk        (clk),
    .reset      (reset),
    .sig_in     (sig_in),
    .enable     (enable),
    .period     (period),
    .high_time  (high_time),
    .valid      (valid),
    .measured   (measured),
    .timeout    (timeout),
    .meas_count (meas_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Drive one input value, advance one clock and sample 1 ns after the edge
  task automatic step(input logic s);
    sig_in = s;
    @(posedge clk);
    #1;
    if (valid) begin
      nval++;
      mc_exp = mc_exp + 8'd1;
      check_eq("meas_count", 32'(meas_count), 32'(mc_exp));
      if (meas_count == 8'd0 && prev_mc == 8'd255) wrap_seen++;
      if (chk_en) begin
        check_eq("period", period, exp_per);
        check_eq("high_time", high_time, exp_hi);
      end
    end
    prev_mc = meas_count;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  task automatic wave(input int per, input int hi, input int nper);
    for (int p = 0; p < nper; p++)
      for (int j = 0; j < per; j++) step(j < hi);
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    sig_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_period", period, 0);
    check_eq("rst_high_time", high_time, 0);
    check_eq("rst_valid", 32'(valid), 0);
    check_eq("rst_measured", 32'(measured), 0);
    check_eq("rst_timeout", 32'(timeout), 0);
    check_eq("rst_meas_count", 32'(meas_count), 0);
    reset = 1'b0;

    // Period 10, high 4
    enable = 1'b1;
    step_n(3);
    chk_en = 1'b1; exp_per = 10; exp_hi = 4; nval = 0;
    wave(10, 4, 5);
    check_eq("p10_valids", nval, 4);
    check_eq("p10_meas_count", 32'(meas_count), 4);
    check_eq("p10_measured", 32'(measured), 1);
    check_eq("p10_period", period, 10);

    // Full-speed toggle
    chk_en = 1'b0;
    wave(2, 1, 2);
    chk_en = 1'b1; exp_per = 2; exp_hi = 1; nval = 0;
    wave(2, 1, 20);
    step_n(2);
    check_eq("tog_valids", nval, 21);
    check_eq("tog_period", period, 2);

    // Timeout after 50 cycles without a rise
    chk_en = 1'b0;
    wave(10, 4, 1);
    chk_en = 1'b1; exp_per = 10; exp_hi = 4;
    wave(10, 4, 2);
    step_n(42);
    check_eq("to_before_timeout", 32'(timeout), 0);
    check_eq("to_before_measured", 32'(measured), 1);
    step(1'b0);
    check_eq("to_timeout", 32'(timeout), 1);
    check_eq("to_measured", 32'(measured), 0);
    check_eq("to_period_hold", period, 10);
    check_eq("to_meas_count_hold", 32'(meas_count), 32'(mc_exp));
    nval = 0;
    wave(10, 4, 2);
    check_eq("to_recover_valids", nval, 1);
    check_eq("to_recover_timeout", 32'(timeout), 0);
    check_eq("to_recover_measured", 32'(measured), 1);

    // Enable dropped for 5 cycles mid-period
    enable = 1'b0; nval = 0;
    step(1'b0); step(1'b1); step(1'b1); step(1'b0); step(1'b0);
    check_eq("en_valids_off", nval, 0);
    check_eq("en_period_hold", period, 10);
    check_eq("en_high_hold", high_time, 4);
    check_eq("en_measured_hold", 32'(measured), 1);
    check_eq("en_meas_count_hold", 32'(meas_count), 32'(mc_exp));
    enable = 1'b1;
    wave(10, 4, 2);
    check_eq("en_reenable_valids", nval, 1);

    // Asynchronous reset between rises
    #3;
    reset = 1'b1;
    #1;
    check_eq("arst_period", period, 0);
    check_eq("arst_high_time", high_time, 0);
    check_eq("arst_valid", 32'(valid), 0);
    check_eq("arst_measured", 32'(measured), 0);
    check_eq("arst_timeout", 32'(timeout), 0);
    check_eq("arst_meas_count", 32'(meas_count), 0);
    mc_exp = 8'd0; prev_mc = 8'd0;
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    step_n(2);
    nval = 0;
    wave(10, 4, 2);
    check_eq("arst_valids", nval, 1);
    check_eq("arst_period_after", period, 10);
    check_eq("arst_meas_count_after", 32'(meas_count), 1);

    // 256 consecutive measurements wrap meas_count
    chk_en = 1'b0;
    wave(2, 1, 2);
    chk_en = 1'b1; exp_per = 2; exp_hi = 1; nval = 0; wrap_seen = 0;
    wave(2, 1, 256);
    check_eq("wrap_valids", nval, 256);
    check_eq("wrap_seen", wrap_seen, 1);
    step_n(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
